bit_trunc_pipe: RTL and testbench

Pipelined, multi-channel saturating bit-truncation stage with selectable rounding, valid/ready flow control and saturation statistics. It narrows CH packed two's-complement accumulator lanes to MSB..LSB fixed-point slices between a conv/FC accumulator and the next layer's input buffer. Rounding carry is computed in an extended (WIDTH+1)-bit domain, so inputs near full scale round without wrap-around. Saturation events are reported per lane and counted.

---
 rtl/bit_trunc_pipe.sv | 148 ++++++++++++++
 tb/tb_bit_trunc_pipe.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_trunc_pipe.sv
// bit_trunc_pipe
//   Two-stage saturating bit-truncation pipe. Each of CH two's-complement lanes of WIDTH bits is
//   rounded (stage 1), then narrowed to bits [MSB:LSB] with saturation to +max/-min (stage 2).
//   Valid/ready flow control with no bubbles; saturation events are flagged per lane and counted.
//
//   Optional feature macro: BIT_TRUNC_PIPE_STAT_EN
//     defined   -> sat_cnt counts transferred beats with any out_sat bit set; sat_clr clears it
//     undefined -> sat_cnt is constant 0 and sat_clr is ignored
//
//   Parameters: CH lanes, WIDTH input lane bits, MSB/LSB kept slice, RND_MODE
//               (0 truncate, 1 round half up, 2 round half to even).
//   Ports:
//     clk, rst          clock, synchronous active-high reset
//     in_valid/in_ready input handshake, din = CH packed WIDTH-bit lanes
//     out_valid/out_ready output handshake, dout = CH packed OW-bit lanes (OW = MSB-LSB+1)
//     out_sat           per-lane saturation flag aligned with dout
//     sat_clr, sat_cnt  saturation statistics clear / 16-bit saturating count
module bit_trunc_pipe #(
   parameter int unsigned CH       = 4,
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned MSB      = 23,
   parameter int unsigned LSB      = 8,
   parameter int unsigned RND_MODE = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CH*WIDTH-1:0]       din,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CH*(MSB-LSB+1)-1:0] dout,
   output logic [CH-1:0]             out_sat,
   input  logic                      sat_clr,
   output logic [15:0]               sat_cnt
);

   localparam int unsigned OW = MSB - LSB + 1;
   // Stage 1 only keeps r[WIDTH:LSB]; the fraction has done its job once the carry is in.
   localparam int unsigned SW = WIDTH - LSB + 1;
   localparam logic [OW-1:0] MinVal = OW'(1) << (OW - 1);
   localparam logic [OW-1:0] MaxVal = ~MinVal;

   logic             w_en1;
   logic             w_en2;
   logic [CH*SW-1:0] w_rnd;
   logic [CH*OW-1:0] w_sat_dout;
   logic [CH-1:0]    w_sat_flag;

   logic             r_s1_valid;
   logic [CH*SW-1:0] r_s1;
   logic             r_out_valid;
   logic [CH*OW-1:0] r_dout;
   logic [CH-1:0]    r_out_sat;

   assign w_en2    = ~r_out_valid | out_ready;
   assign w_en1    = ~r_s1_valid | w_en2;
   assign in_ready = w_en1;

   for (genvar i = 0; i < CH; i++) begin : g_lane
      logic [WIDTH:0]  w_x;
      logic [SW-1:0]   w_s;
      logic [SW-OW:0]  w_top;

      // One extra sign bit so a round-up carry at full scale cannot wrap.
      assign w_x = {din[i*WIDTH + WIDTH - 1], din[i*WIDTH +: WIDTH]};

      if (LSB == 0) begin : g_no_rnd
         assign w_rnd[i*SW +: SW] = w_x;
      end else begin : g_rnd
         localparam logic [LSB-1:0] Half = LSB'(1) << (LSB - 1);
         logic           w_inc;
         logic [LSB-1:0] w_unused_frac;

         if (RND_MODE == 0) begin : g_trunc
            assign w_inc = 1'b0;
         end else if (RND_MODE == 1) begin : g_up
            assign w_inc = 1'b1;
         end else begin : g_even
            logic [LSB-1:0] w_frac;
            assign w_frac = w_x[LSB-1:0];
            // Exact ties go up only when the kept LSB is odd.
            assign w_inc  = (w_frac > Half) | ((w_frac == Half) & w_x[LSB]);
         end

         assign {w_rnd[i*SW +: SW], w_unused_frac} = w_x + (w_inc ? (WIDTH+1)'(Half) : '0);
      end

      // Stage 2: bits r[WIDTH:MSB] must all equal the sign, otherwise the slice overflowed.
      assign w_s   = r_s1[i*SW +: SW];
      assign w_top = w_s[SW-1:OW-1];
      assign w_sat_flag[i] = ~((&w_top) | (~|w_top));
      assign w_sat_dout[i*OW +: OW] = !w_sat_flag[i] ? w_s[OW-1:0] :
                                      (w_s[SW-1] ? MinVal : MaxVal);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid  <= 1'b0;
         r_s1        <= '0;
         r_out_valid <= 1'b0;
         r_dout      <= '0;
         r_out_sat   <= '0;
      end else begin
         if (w_en1) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
               r_s1 <= w_rnd;
            end
         end
         if (w_en2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
               r_dout    <= w_sat_dout;
               r_out_sat <= w_sat_flag;
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign dout      = r_dout;
   assign out_sat   = r_out_sat;

`ifdef BIT_TRUNC_PIPE_STAT_EN
   logic        w_sat_xfer;
   logic [15:0] r_sat_cnt;

   assign w_sat_xfer = r_out_valid & out_ready & (|r_out_sat);

   // Clear wins over a coincident increment; the count sticks at all-ones.
   always_ff @(posedge clk) begin
      if (rst || sat_clr) begin
         r_sat_cnt <= '0;
      end else if (w_sat_xfer && (r_sat_cnt != 16'hFFFF)) begin
         r_sat_cnt <= r_sat_cnt + 16'd1;
      end
   end

   assign sat_cnt = r_sat_cnt;
`else
   logic w_unused_sat_clr;

   assign w_unused_sat_clr = sat_clr;
   assign sat_cnt          = '0;
`endif

endmodule

// File: tb/tb_bit_trunc_pipe.sv
// Testbench for bit_trunc_pipe: three instances (RND_MODE 0/1/2) share the same stimulus and
// are compared against a behavioural model (integer floor/round/clamp plus a beat queue).
module tb_bit_trunc_pipe;

   localparam int CH    = 2;
   localparam int WIDTH = 16;
   localparam int MSB   = 11;
   localparam int LSB   = 4;
`ifdef BIT_TRUNC_PIPE_STAT_EN
   localparam bit STAT_EN = 1'b1;
`else
   localparam bit STAT_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] d;
      int          acc;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic        sat_clr;
   logic [31:0] din;

   logic        in_ready_m  [3];
   logic        out_valid_m [3];
   logic [15:0] dout_m      [3];
   logic [1:0]  sat_m       [3];
   logic [15:0] cnt_m       [3];

   int          checks   = 0;
   int          failures = 0;
   int          cyc      = 0;
   beat_t       q[$];
   logic [15:0] cnt_ref  [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      bit_trunc_pipe #(
         .CH(CH), .WIDTH(WIDTH), .MSB(MSB), .LSB(LSB), .RND_MODE(g)
      ) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m[g]), .din(din),
         .out_valid(out_valid_m[g]), .out_ready(out_ready), .dout(dout_m[g]),
         .out_sat(sat_m[g]), .sat_clr(sat_clr), .sat_cnt(cnt_m[g])
      );
   end

   // Reference: value / 16 with the chosen rounding, clamped to the signed 8-bit range.
   function automatic logic [8:0] ref_lane(input logic [15:0] v, input int mode);
      int   val, frac, qt;
      logic s;
      val  = int'($signed(v));
      frac = val & 15;
      qt   = (val - frac) / 16;
      if (mode == 1 && frac >= 8) qt++;
      if (mode == 2 && (frac > 8 || (frac == 8 && (qt % 2) != 0))) qt++;
      s = 1'b0;
      if (qt > 127) begin qt = 127; s = 1'b1; end
      if (qt < -128) begin qt = -128; s = 1'b1; end
      return {s, qt[7:0]};
   endfunction

   function automatic logic [17:0] ref_beat(input logic [31:0] d, input int mode);
      logic [8:0] l0, l1;
      l0 = ref_lane(d[15:0], mode);
      l1 = ref_lane(d[31:16], mode);
      return {l1[8], l0[8], l1[7:0], l0[7:0]};
   endfunction

   // Head beat is visible two cycles after the cycle it was accepted in.
   function automatic bit exp_valid();
      if (q.size() == 0) return 1'b0;
      return (cyc - q[0].acc) >= 2;
   endfunction

   function automatic logic [15:0] rand_lane();
      case ($urandom_range(0, 3))
         0: return 16'(int'($urandom_range(0, 4095)) - 2048);
         1: return 16'(int'($urandom_range(0, 63)) * 16 + 8 - 512);
         2: return $urandom_range(0, 1) ? 16'(32'h07E0 + $urandom_range(0, 47))
                                        : 16'(32'hF7E0 + $urandom_range(0, 47));
         default: return 16'($urandom);
      endcase
   endfunction

   function automatic logic [31:0] bp_beat(input int k);
      return {16'(32'h0108 + k * 16), 16'(32'h07C8 + k * 16)};
   endfunction

   // Advance one clock and update the model from the inputs presented this cycle.
   task automatic advance();
      bit          acc, xfer, was_rst;
      logic [17:0] r;
      was_rst = rst;
      acc     = in_valid && (out_ready || q.size() < 2);
      xfer    = exp_valid() && out_ready;
      if (!was_rst) begin
         for (int m = 0; m < 3; m++) begin
            r = xfer ? ref_beat(q[0].d, m) : 18'h0;
            if (sat_clr) cnt_ref[m] = 16'h0;
            else if (xfer && r[17:16] != 2'b00 && cnt_ref[m] != 16'hFFFF) cnt_ref[m]++;
         end
         if (xfer) void'(q.pop_front());
         if (acc) q.push_back('{d: din, acc: cyc});
      end
      @(posedge clk);
      if (was_rst) begin
         q.delete();
         for (int m = 0; m < 3; m++) cnt_ref[m] = 16'h0;
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; din = 32'h1234_5678; out_ready = 1'b0; sat_clr = 1'b0;
      advance();
      advance();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (out_valid_m[m] !== 1'b0) begin
            failures++; $display("FAIL reset_out_valid m=%0d got=%b exp=0", m, out_valid_m[m]);
         end
         checks++;
         if (dout_m[m] !== 16'h0) begin
            failures++; $display("FAIL reset_dout m=%0d got=%h exp=0000", m, dout_m[m]);
         end
         checks++;
         if (sat_m[m] !== 2'b00) begin
            failures++; $display("FAIL reset_out_sat m=%0d got=%b exp=00", m, sat_m[m]);
         end
         checks++;
         if (cnt_m[m] !== 16'h0) begin
            failures++; $display("FAIL reset_sat_cnt m=%0d got=%h exp=0000", m, cnt_m[m]);
         end
         checks++;
         if (in_ready_m[m] !== 1'b1) begin
            failures++; $display("FAIL reset_in_ready m=%0d got=%b exp=1", m, in_ready_m[m]);
         end
      end
   endtask

   task automatic test_directed();
      logic [31:0] vec [6];
      logic [17:0] exp;
      vec = '{32'h0017_0018, 32'h0028_0018, 32'h0038_FFE8, 32'hFFF1_001F,
              32'h7FF8_07F8, 32'h8000_F7F0};
      out_ready = 1'b1;
      foreach (vec[k]) begin
         in_valid = 1'b1; din = vec[k];
         #1;
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (in_ready_m[m] !== 1'b1) begin
               failures++; $display("FAIL dir_in_ready v=%0d m=%0d got=%b exp=1", k, m,
                                    in_ready_m[m]);
            end
         end
         advance();
         in_valid = 1'b0; din = '0;
         #1;
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (out_valid_m[m] !== 1'b0) begin
               failures++; $display("FAIL dir_early_valid v=%0d m=%0d got=%b exp=0", k, m,
                                    out_valid_m[m]);
            end
         end
         advance();
         #1;
         for (int m = 0; m < 3; m++) begin
            exp = ref_beat(vec[k], m);
            checks++;
            if (out_valid_m[m] !== 1'b1) begin
               failures++; $display("FAIL dir_latency v=%0d m=%0d got=%b exp=1", k, m,
                                    out_valid_m[m]);
            end
            checks++;
            if ({sat_m[m], dout_m[m]} !== exp) begin
               failures++; $display("FAIL dir_data v=%0d m=%0d got=%h exp=%h", k, m,
                                    {sat_m[m], dout_m[m]}, exp);
            end
         end
         advance();
      end
   endtask

   task automatic test_random_stream();
      logic [15:0] prev [3];
      logic [17:0] exp;
      bit          stall, ev;
      stall = 1'b0;
      for (int c = 0; c < 400; c++) begin
         in_valid  = (c < 380) && ($urandom_range(0, 3) != 0);
         din       = {rand_lane(), rand_lane()};
         out_ready = (c >= 380) || ($urandom_range(0, 2) != 0);
         sat_clr   = ($urandom_range(0, 15) == 0);
         #1;
         ev = exp_valid();
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (in_ready_m[m] !== (out_ready || q.size() < 2)) begin
               failures++; $display("FAIL rnd_in_ready c=%0d m=%0d got=%b exp=%b", c, m,
                                    in_ready_m[m], (out_ready || q.size() < 2));
            end
            checks++;
            if (out_valid_m[m] !== ev) begin
               failures++; $display("FAIL rnd_out_valid c=%0d m=%0d got=%b exp=%b", c, m,
                                    out_valid_m[m], ev);
            end
            if (ev) begin
               exp = ref_beat(q[0].d, m);
               checks++;
               if ({sat_m[m], dout_m[m]} !== exp) begin
                  failures++; $display("FAIL rnd_data c=%0d m=%0d got=%h exp=%h", c, m,
                                       {sat_m[m], dout_m[m]}, exp);
               end
            end
            if (stall) begin
               checks++;
               if (dout_m[m] !== prev[m]) begin
                  failures++; $display("FAIL rnd_stable c=%0d m=%0d got=%h exp=%h", c, m,
                                       dout_m[m], prev[m]);
               end
            end
            checks++;
            if (cnt_m[m] !== (STAT_EN ? cnt_ref[m] : 16'h0)) begin
               failures++; $display("FAIL rnd_sat_cnt c=%0d m=%0d got=%h exp=%h", c, m,
                                    cnt_m[m], (STAT_EN ? cnt_ref[m] : 16'h0));
            end
            prev[m] = dout_m[m];
         end
         stall = ev && !out_ready;
         advance();
      end
      sat_clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_backpressure();
      int          acc_n, out_n;
      bit          saw_block, stall, bp_acc;
      logic [15:0] prev [3];
      logic [17:0] exp;
      acc_n = 0; out_n = 0; saw_block = 1'b0; stall = 1'b0;
      for (int c = 0; c < 40 && out_n < 10; c++) begin
         in_valid  = (acc_n < 10);
         din       = bp_beat(acc_n);
         out_ready = !(c >= 3 && c <= 7);
         #1;
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (in_ready_m[m] !== (out_ready || (acc_n - out_n) < 2)) begin
               failures++; $display("FAIL bp_in_ready c=%0d m=%0d got=%b exp=%b", c, m,
                                    in_ready_m[m], (out_ready || (acc_n - out_n) < 2));
            end
            if (!out_ready && (acc_n - out_n) >= 2 && in_ready_m[m] === 1'b0) saw_block = 1'b1;
            checks++;
            if (out_valid_m[m] !== exp_valid()) begin
               failures++; $display("FAIL bp_out_valid c=%0d m=%0d got=%b exp=%b", c, m,
                                    out_valid_m[m], exp_valid());
            end
            if (exp_valid()) begin
               exp = ref_beat(bp_beat(out_n), m);
               checks++;
               if ({sat_m[m], dout_m[m]} !== exp) begin
                  failures++; $display("FAIL bp_order c=%0d m=%0d beat=%0d got=%h exp=%h", c, m,
                                       out_n, {sat_m[m], dout_m[m]}, exp);
               end
            end
            if (stall) begin
               checks++;
               if (dout_m[m] !== prev[m]) begin
                  failures++; $display("FAIL bp_stable c=%0d m=%0d got=%h exp=%h", c, m,
                                       dout_m[m], prev[m]);
               end
            end
            prev[m] = dout_m[m];
         end
         stall  = exp_valid() && !out_ready;
         bp_acc = in_valid && (out_ready || (acc_n - out_n) < 2);
         if (exp_valid() && out_ready) out_n++;
         if (bp_acc) acc_n++;
         advance();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      checks++;
      if (out_n != 10) begin
         failures++; $display("FAIL bp_count got=%0d exp=10", out_n);
      end
      checks++;
      if (saw_block !== 1'b1) begin
         failures++; $display("FAIL bp_block got=%b exp=1", saw_block);
      end
   endtask

   task automatic test_stats();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
      advance();
      rst = 1'b0; din = 32'h8000_7FF8;
      in_valid = 1'b1;
      repeat (3) advance();
      in_valid = 1'b0;
      repeat (2) advance();
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (cnt_m[m] !== (STAT_EN ? 16'd3 : 16'd0)) begin
            failures++; $display("FAIL stat_three m=%0d got=%0d exp=%0d", m, cnt_m[m],
                                 (STAT_EN ? 3 : 0));
         end
      end
      in_valid = 1'b1;
      advance();
      in_valid = 1'b0;
      advance();
      sat_clr = 1'b1;
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (out_valid_m[m] !== 1'b1 || sat_m[m] !== 2'b11) begin
            failures++; $display("FAIL stat_fourth_beat m=%0d got=%b/%b exp=1/11", m,
                                 out_valid_m[m], sat_m[m]);
         end
      end
      advance();
      sat_clr = 1'b0;
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (cnt_m[m] !== 16'd0) begin
            failures++; $display("FAIL stat_clr_priority m=%0d got=%0d exp=0", m, cnt_m[m]);
         end
      end
      in_valid = 1'b1;
      advance();
      in_valid = 1'b0;
      repeat (2) advance();
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (cnt_m[m] !== (STAT_EN ? 16'd1 : 16'd0)) begin
            failures++; $display("FAIL stat_after_clr m=%0d got=%0d exp=%0d", m, cnt_m[m],
                                 (STAT_EN ? 1 : 0));
         end
      end
   endtask

   task automatic test_reset_midstream();
      out_ready = 1'b0; in_valid = 1'b1; din = 32'h8000_7FF8;
      repeat (3) advance();
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (out_valid_m[m] !== 1'b1 || in_ready_m[m] !== 1'b0) begin
            failures++; $display("FAIL mid_full m=%0d got=%b/%b exp=1/0", m, out_valid_m[m],
                                 in_ready_m[m]);
         end
      end
      rst = 1'b1; in_valid = 1'b0;
      advance();
      rst = 1'b0;
      #1;
      for (int m = 0; m < 3; m++) begin
         checks++;
         if (out_valid_m[m] !== 1'b0) begin
            failures++; $display("FAIL mid_rst_valid m=%0d got=%b exp=0", m, out_valid_m[m]);
         end
         checks++;
         if (cnt_m[m] !== 16'd0) begin
            failures++; $display("FAIL mid_rst_cnt m=%0d got=%0d exp=0", m, cnt_m[m]);
         end
      end
      out_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         advance();
         #1;
         for (int m = 0; m < 3; m++) begin
            checks++;
            if (out_valid_m[m] !== 1'b0) begin
               failures++; $display("FAIL mid_leftover c=%0d m=%0d got=%b exp=0", c, m,
                                    out_valid_m[m]);
            end
         end
      end
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0; din = '0;
      for (int m = 0; m < 3; m++) cnt_ref[m] = 16'h0;
      test_reset();
      test_directed();
      test_random_stream();
      test_backpressure();
      test_stats();
      test_reset_midstream();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "watchdog");
   end

endmodule
